// File: rtl/pipe_track.sv
// Parametrised pipeline-tracking chain: valid/wr/dest/payload per stage with stall,
// bubble, range flush and RAW lookup. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_track #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REGW      = 3,
    parameter int unsigned BUBBLE_AT = 1,
    parameter int unsigned HAZ_LO    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       bubble,
    input  logic                       flush,
    input  logic [$clog2(DEPTH)-1:0]   flush_upto,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_wr,
    input  logic [REGW-1:0]            in_dest,
    input  logic [WIDTH-1:0]           in_payload,
    input  logic [REGW-1:0]            src_a,
    input  logic [REGW-1:0]            src_b,
    input  logic                       src_a_en,
    input  logic                       src_b_en,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic [$clog2(DEPTH)-1:0]   hazard_a_stage,
    output logic [$clog2(DEPTH)-1:0]   hazard_b_stage,
    output logic [DEPTH-1:0]           stage_valid,
    output logic                       out_valid,
    output logic                       out_wr,
    output logic [REGW-1:0]            out_dest,
    output logic [WIDTH-1:0]           out_payload,
    output logic [15:0]                bubble_cnt,
    output logic [15:0]                flush_cnt
);

    localparam int unsigned SW = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic [REGW-1:0]  dest;
        logic [WIDTH-1:0] payload;
    } stage_t;

    stage_t stg  [DEPTH];
    stage_t prev [DEPTH];
    stage_t nxt  [DEPTH];

    assign in_ready = ~stall & ~bubble;

    // Value each stage would take on a normal advance.
    always_comb begin
        prev[0] = '{valid: in_valid, wr: in_wr, dest: in_dest, payload: in_payload};
        for (int k = 1; k < int'(DEPTH); k++) begin
            prev[k] = stg[k-1];
        end
    end

    // Next state: stall, then bubble, then advance; flush overrides valid/wr on top.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            nxt[k] = stg[k];
            if (!stall) begin
                if (bubble) begin
                    if (k == int'(BUBBLE_AT)) begin
                        nxt[k].valid = 1'b0;
                        nxt[k].wr    = 1'b0;
                    end else if (k > int'(BUBBLE_AT)) begin
                        nxt[k] = prev[k];
                    end
                end else begin
                    nxt[k] = prev[k];
                end
            end
            if (flush && (int'(flush_upto) >= k)) begin
                nxt[k].valid = 1'b0;
                nxt[k].wr    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!rst_n) begin
                stg[k] <= '0;
            end else begin
                stg[k] <= nxt[k];
            end
        end
    end

    // RAW lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        hazard_a       = 1'b0;
        hazard_b       = 1'b0;
        hazard_a_stage = '0;
        hazard_b_stage = '0;
        for (int k = int'(DEPTH) - 1; k >= int'(HAZ_LO); k--) begin
            if (src_a_en && stg[k].valid && stg[k].wr && (stg[k].dest == src_a)) begin
                hazard_a       = 1'b1;
                hazard_a_stage = SW'(k);
            end
            if (src_b_en && stg[k].valid && stg[k].wr && (stg[k].dest == src_b)) begin
                hazard_b       = 1'b1;
                hazard_b_stage = SW'(k);
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            stage_valid[k] = stg[k].valid;
        end
    end

    assign out_valid   = stg[DEPTH-1].valid;
    assign out_wr      = stg[DEPTH-1].valid & stg[DEPTH-1].wr;
    assign out_dest    = stg[DEPTH-1].dest;
    assign out_payload = stg[DEPTH-1].payload;

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= 16'd0;
            flush_cnt  <= 16'd0;
        end else begin
            if (bubble && !stall && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign bubble_cnt = 16'd0;
    assign flush_cnt  = 16'd0;
`endif

endmodule

// File: doc/pipe_track.md
# pipe_track

Parametrised pipeline-tracking register chain for the LC-3b pipelined core. It replaces hand-instantiated per-stage control, destination-register and payload registers with one DEPTH-stage chain. Each stage carries a valid bit, a regfile-write flag, a destination register and a payload word. It supports global stall, bubble insertion for hazard stalls, range flush for branch redirect, and combinational RAW-hazard lookup against the decode-stage source registers.

## Interface
- DEPTH, 4: number of stages (2..8); stage 0 is youngest and stage DEPTH-1 is oldest.
- WIDTH, 16: payload width (control word, PC or data).
- REGW, 3: destination/source register index width.
- BUBBLE_AT, 1: stage that receives the bubble (1..DEPTH-1).
- HAZ_LO, 0: youngest stage included in hazard lookup.
- SW = $clog2(DEPTH): width of stage-index ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  freezes every stage (memory wait).
- bubble  in  1  hazard stall: younger stages hold and a bubble is injected at BUBBLE_AT.
- flush  in  1  invalidates stages 0..flush_upto.
- flush_upto  in  SW  oldest stage to invalidate.
- in_valid  in  1  new entry offered to stage 0.
- in_ready  out  1  = ~stall & ~bubble; an entry is accepted when in_valid & in_ready.
- in_wr, in_dest, in_payload  in  1/REGW/WIDTH  entry fields.
- src_a, src_b  in  REGW  source registers to check.
- src_a_en, src_b_en  in  1  the corresponding source is actually read.
- hazard_a, hazard_b  out  1  RAW match found.
- hazard_a_stage, hazard_b_stage  out  SW  youngest matching stage; 0 when there is no match.
- stage_valid  out  DEPTH  valid bit of each stage.
- out_valid, out_wr, out_dest, out_payload  out  1/1/REGW/WIDTH  contents of stage DEPTH-1.
- bubble_cnt, flush_cnt  out  16  performance counters (see Configuration).

## Operation
- Update priority per edge: reset, then flush (valid bits only), then stall, then bubble, then normal advance.
- Normal advance (stall=0, bubble=0):
  - stage k+1 takes stage k.
  - stage 0 takes the in_* fields, with valid = in_valid.
  - the oldest entry is retired.
- stall=1: every field of every stage holds, and in_ready=0.
- bubble=1 with stall=0:
  - stages 0..BUBBLE_AT-1 hold.
  - stage BUBBLE_AT gets valid=0; its wr is forced to 0 and its other fields are don't-care.
  - stages above BUBBLE_AT advance.
  - in_ready=0.
- flush=1:
  - after the edge, stages 0..flush_upto have valid=0 and wr=0.
  - the remaining stages get their stall/bubble/advance value.
  - flush applies even when stall=1; in that case only the valid bits change.
- flush_upto >= DEPTH-1 clears the whole pipe. An entry accepted on a flush edge is discarded if flush_upto >= 0, which is always the case.
- Hazard lookup (combinational):
  - hazard_x = src_x_en & OR over k in HAZ_LO..DEPTH-1 of (valid_k & wr_k & dest_k==src_x).
  - hazard_x_stage is the lowest such k.
  - R0 is an ordinary register and is not excluded.
- Entries with valid=0 never cause a hazard and never assert out_wr. out_wr = valid & wr of stage DEPTH-1.

## Timing
- Reset (rst_n=0 at an edge): all valid, wr, dest and payload fields are 0 and both counters are 0. As a result out_valid=0, out_wr=0, out_dest=0, out_payload=0, stage_valid=0, hazard_*=0, hazard_*_stage=0, and in_ready follows its inputs.
- Reset asserted mid-operation discards all in-flight entries on that edge.
- Latency: an entry accepted at edge t appears on the out_* ports after edge t+DEPTH-1, assuming no stall or bubble. Each stall or bubble cycle affecting that entry's stage adds one cycle.
- Hazard outputs respond in the same cycle as src_* and stage contents; there is no register.
- in_ready is purely combinational from stall and bubble.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - bubble_cnt increments on each edge with bubble=1 & stall=0.
  - flush_cnt increments on each edge with flush=1.
  - both saturate at 16'hFFFF and are cleared by reset.
- PIPE_PERF_CNT_EN undefined: the counters are not built and bubble_cnt and flush_cnt are tied to 0.

## Test plan
- Fill and drain:
  - stimulus: DEPTH=4, insert payloads 0x1000,0x1002,0x1004 on consecutive cycles, then in_valid=0.
  - response: out_payload=0x1000 after the 4th edge, followed by 0x1002 and 0x1004, then out_valid=0.
- Stall:
  - stimulus: pipe full, stall=1 for 3 cycles.
  - response: all stage_valid and out_* unchanged; in_ready=0; the stream resumes unchanged afterwards.
- Bubble:
  - stimulus: BUBBLE_AT=1, stages 0..3 valid, bubble=1 for one edge.
  - response: stage_valid=4'b1101; the stage 0 payload is unchanged; the old stage 2 entry is now in stage 3.
- Flush during stall:
  - stimulus: full pipe, stall=1, flush=1, flush_upto=1.
  - response: stage_valid=4'b1100; payloads held; out_wr still follows stage 3.
- Hazard:
  - stimulus: stage 1 holds dest=3,wr=1 and stage 3 holds dest=3,wr=1; src_a=3, src_a_en=1.
  - response: hazard_a=1, hazard_a_stage=1; with src_a_en=0 the response is hazard_a=0.
- Counters (PIPE_PERF_CNT_EN):
  - stimulus: 5 bubble cycles, 2 flush cycles, then reset mid-stream.
  - response: bubble_cnt=5 and flush_cnt=2 before the reset; both 0 and all valid bits 0 after the reset edge.
